// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU: sequencer state encodings and
// default widths/latencies used by the pipeline control logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  localparam int REGADDR_W        = 3;
  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags when the instruction in ID reads a
// register that the load currently in EX has not yet produced.
module hazard_detect #(
  parameter int REGADDR_W = cpu_pkg::REGADDR_W
) (
  input  logic [REGADDR_W-1:0] id_rs,
  input  logic [REGADDR_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REGADDR_W-1:0] ex_rd,
  output logic                 lu
);

  // r0 is compared like any other register; rt only matters when it is read.
  always_comb begin
    lu = ex_mem_read & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: load-use stall, MEM-stage branch flush, debug
// run/halt/step FSM with pipeline drain, and saturating event counters.
module pipe_ctrl #(
  parameter int REGADDR_W    = cpu_pkg::REGADDR_W,
  parameter int DRAIN_CYCLES = cpu_pkg::DRAIN_CYCLES_DEF,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REGADDR_W-1:0] id_rs,
  input  logic [REGADDR_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REGADDR_W-1:0] ex_rd,
  input  logic                 branch_taken,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 run_req,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  import cpu_pkg::*;

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_e               state_q, state_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 lu;

  hazard_detect #(
    .REGADDR_W(REGADDR_W)
  ) u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .lu         (lu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state plus the per-state default controls; branch and load-use
  // overrides are layered on afterwards so they win in every state.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        pc_write = 1'b1;
        if (halt_req && !lu) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if_id_flush = 1'b1;
        if (!lu) begin
          if (drain_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if_id_stall = 1'b1;
        if (run_req) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        pc_write = 1'b1;
        if (branch_taken || !lu) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (branch_taken) begin
      pc_write     = 1'b1;
      pc_sel       = 1'b1;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_stall  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b0;
    end

    if (reset) begin
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu && !branch_taken && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (branch_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_comb begin
    halted    = (state_q == ST_HALTED) && !reset;
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazards, branch priority,
// halt/drain/step/resume sequencing, counter saturation and reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [2:0]  ex_rd;
  logic        branch_taken;
  logic        halt_req;
  logic        step_req;
  logic        run_req;
  logic        pc_write;
  logic        pc_sel;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int compared   = 0;
  int mismatched = 0;
  int stallExp   = 0;

  pipe_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .run_req     (run_req),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] rs, input logic [2:0] rt,
                               input logic usesRt, input logic memRead,
                               input logic [2:0] rd, input logic br,
                               input logic halt, input logic step,
                               input logic run);
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = usesRt;
    ex_mem_read  = memRead;
    ex_rd        = rd;
    branch_taken = br;
    halt_req     = halt;
    step_req     = step;
    run_req      = run;
  endtask

  task automatic applyIdle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyIdle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_pc_write", {31'd0, pc_write}, 32'd0);
    checkOutput("rst_flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    nextCycle();
    reset = 1'b0;

    // Load-use on rs for a single cycle
    applyStimulus(3'd3, 3'd6, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lu_pc_write", {31'd0, pc_write}, 32'd0);
    checkOutput("lu_stall", {31'd0, if_id_stall}, 32'd1);
    checkOutput("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    checkOutput("lu_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    stallExp++;
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("lu_after_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("lu_after_stall", {31'd0, if_id_stall}, 32'd0);
    checkOutput("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // rt match but rt unused: no hazard
    nextCycle();
    applyStimulus(3'd5, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("nofalse_stall", {31'd0, if_id_stall}, 32'd0);
    checkOutput("nofalse_pc_write", {31'd0, pc_write}, 32'd1);
    nextCycle();
    applyStimulus(3'd3, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("noload_stall", {31'd0, if_id_stall}, 32'd0);
    nextCycle();
    applyStimulus(3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lu_rt_stall", {31'd0, if_id_stall}, 32'd1);
    stallExp++;
    nextCycle();
    applyStimulus(3'd0, 3'd6, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lu_r0_stall", {31'd0, if_id_stall}, 32'd1);
    stallExp++;
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("stall_cnt_3", {16'd0, stall_cnt}, stallExp);

    // Branch beats load-use
    nextCycle();
    applyStimulus(3'd3, 3'd6, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("br_pc_sel", {31'd0, pc_sel}, 32'd1);
    checkOutput("br_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("br_flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 32'd7);
    checkOutput("br_stall", {31'd0, if_id_stall}, 32'd0);
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    checkOutput("br_stall_cnt", {16'd0, stall_cnt}, stallExp);
    checkOutput("br_after_pc_sel", {31'd0, pc_sel}, 32'd0);

    // Halt and drain
    nextCycle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("halt_req_pc_write", {31'd0, pc_write}, 32'd1);
    nextCycle();
    applyIdle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("drain%0d_pc_write", i), {31'd0, pc_write}, 32'd0);
      checkOutput($sformatf("drain%0d_if_id_flush", i), {31'd0, if_id_flush}, 32'd1);
      checkOutput($sformatf("drain%0d_halted", i), {31'd0, halted}, 32'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("halted_after_drain", {31'd0, halted}, 32'd1);
    checkOutput("halted_stall", {31'd0, if_id_stall}, 32'd1);
    checkOutput("halted_pc_write", {31'd0, pc_write}, 32'd0);

    // Single step
    nextCycle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("step_req_halted", {31'd0, halted}, 32'd1);
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("step_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("step_halted", {31'd0, halted}, 32'd0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sdrain%0d_pc_write", i), {31'd0, pc_write}, 32'd0);
      checkOutput($sformatf("sdrain%0d_if_id_flush", i), {31'd0, if_id_flush}, 32'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("step_rehalted", {31'd0, halted}, 32'd1);

    // run_req wins over step_req
    nextCycle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("resume_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("resume_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    checkOutput("resume_halted", {31'd0, halted}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("resume2_pc_write", {31'd0, pc_write}, 32'd1);

    // Drain with a load-use cycle injected: halted one cycle later
    nextCycle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyIdle();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        applyStimulus(3'd4, 3'd6, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        stallExp++;
      end else begin
        applyIdle();
      end
      @(negedge clk);
      checkOutput($sformatf("ludrain%0d_halted", i), {31'd0, halted}, 32'd0);
      checkOutput($sformatf("ludrain%0d_pc_write", i), {31'd0, pc_write}, 32'd0);
      if (i == 2) begin
        checkOutput("ludrain_stall", {31'd0, if_id_stall}, 32'd1);
        checkOutput("ludrain_if_id_flush", {31'd0, if_id_flush}, 32'd0);
      end
      nextCycle();
    end
    applyIdle();
    @(negedge clk);
    checkOutput("ludrain_halted", {31'd0, halted}, 32'd1);
    checkOutput("ludrain_stall_cnt", {16'd0, stall_cnt}, stallExp);

    // Resume, then saturate the stall counter
    nextCycle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(3'd3, 3'd6, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    applyIdle();
    @(negedge clk);
    checkOutput("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    checkOutput("sat_pc_write", {31'd0, pc_write}, 32'd1);

    // Reset during drain
    nextCycle();
    applyStimulus(3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("predrain_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstdrain_pc_write", {31'd0, pc_write}, 32'd0);
    checkOutput("rstdrain_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postrst_pc_write", {31'd0, pc_write}, 32'd1);
    checkOutput("postrst_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    checkOutput("postrst_halted", {31'd0, halted}, 32'd0);
    checkOutput("postrst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("postrst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
